aes_round_scheduler: RTL
========================

# aes_round_scheduler

Sequencer for the byte-serial AES round datapath. It accepts one 16-byte block as a byte stream and steps it through the initial AddRoundKey and NR rounds by looping bytes back through the round logic. It drives the byte permutation unit's direction and synchronous restart so that unit's free-running counter stays aligned to block boundaries. It also requests round keys and flags the output bytes.

## Interface
Parameters:
- NR, 10: number of rounds; legal values 10, 12, 14.
- LAT, 12: datapath latency in cycles from a byte entering the round logic to it leaving; legal 1..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a block; accepted only when busy=0.
- encrypt  in  1  direction, sampled with accepted start: 1 = encrypt, 0 = decrypt.
- in_valid  in  1  input byte present on the datapath input.
- in_ready  out  1  scheduler is taking input bytes (LOAD state).
- bpu_rst_synch  out  1  synchronous restart to the byte permutation unit controller.
- bpu_shift_left  out  1  permutation direction; equals the latched encrypt.
- sel_in  out  1  datapath input mux: 0 = external byte, 1 = loopback byte.
- round_idx  out  4  round of the byte currently entering; 0 = initial AddRoundKey.
- byte_idx  out  4  slot 0..15 within the current round.
- last_round  out  1  round_idx==NR; datapath skips (Inv)MixColumns.
- key_req  out  1  one-cycle request for round key key_idx.
- key_idx  out  4  index of the requested key.
- out_valid  out  1  datapath output byte is a final ciphertext/plaintext byte.
- done  out  1  one-cycle pulse on the 16th out_valid cycle.
- load_err  out  1  one-cycle pulse; the input stream had a bubble.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, ROUND, FLUSH.
- IDLE:
  - bpu_rst_synch=1; all other outputs 0.
  - start=1 latches encrypt and moves to LOAD with byte_idx=0, round_idx=0.
- LOAD (16 cycles):
  - in_ready=1, sel_in=0, bpu_rst_synch=0.
  - in_valid must be 1 in every LOAD cycle. in_valid=0 in any LOAD cycle: load_err pulses that cycle and the next state is IDLE.
  - On slot 15, go to ROUND with round_idx=1.
- ROUND (16 cycles per round):
  - sel_in=1; byte_idx increments every cycle and wraps 15->0.
  - On wrap, round_idx increments.
  - After slot 15 of round NR, go to FLUSH.
- key_req pulses at slot 15 of LOAD and of each round r<NR, with key_idx=round_idx+1.
- out_valid covers 16 consecutive cycles:
  - First cycle: LAT cycles after slot 0 of round NR.
  - Last cycle: final FLUSH cycle.
- FLUSH lasts LAT cycles; round_idx and byte_idx hold 0.
  - On its last cycle done=1; the next state is IDLE.
- start is ignored while busy=1.
- rst=1 in any state: next cycle IDLE, all counters 0, bpu_rst_synch=1, all pulses 0. Any in-flight block is discarded with no done.
- Counters:
  - byte_idx: 4-bit, natural wrap.
  - round_idx: 4-bit, never exceeds NR.
  - Flush counter: 5-bit.

## Timing
- Control outputs are registered from state and counters. Exceptions, which are combinational from inputs:
  - load_err = LOAD & ~in_valid.
  - in_ready = (state==LOAD).
- Start accepted at cycle 0 means LOAD slot 0 is cycle 1.
  - bpu_rst_synch is high at cycle 0 and low from cycle 1.
  - The permutation controller therefore counts 0 at LOAD slot 0.
- Total block time (IDLE excluded): 16*(NR+1)+LAT cycles.
  - NR=10, LAT=12: 188 cycles. done is at cycle 188 after start.
- A new start is accepted at the earliest on the cycle after done. Minimum block-to-block period is 189 cycles.
- Simultaneous rst and start: rst wins.

## Configuration
- AES_SCHED_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD, ROUND or FLUSH gives IDLE next cycle.
  - out_valid, key_req and done are forced 0 in that cycle. bpu_rst_synch rises the next cycle.
  - abort in IDLE has no effect. Simultaneous abort and start in IDLE: start is accepted.
- AES_SCHED_ABORT_EN not defined: no abort port; only rst leaves a non-IDLE state early.

## Test plan
- NR=10, LAT=12, encrypt=1, start at cycle 0, in_valid held high:
  - in_ready high cycles 1-16.
  - bpu_shift_left=1 from cycle 1.
  - key_req at cycles 16, 32 … 160 with key_idx 1..10.
  - last_round high cycles 161-176.
  - out_valid high cycles 173-188; done at cycle 188.
- encrypt=0, otherwise the same: bpu_shift_left=0 for the whole block; all other timing identical.
- in_valid dropped at LOAD slot 7 (cycle 8): load_err=1 at cycle 8, IDLE at cycle 9, no key_req, no done.
- start pulsed at cycle 50 of an active block: ignored; the block completes unchanged; busy stays 1.
- rst asserted at ROUND round_idx=4, byte_idx=9: next cycle IDLE, busy=0, bpu_rst_synch=1, no out_valid or done. A start two cycles later runs a clean 188-cycle block.
- NR=14, LAT=16 (and, with AES_SCHED_ABORT_EN, abort at cycle 100):
  - Without abort: done at cycle 256.
  - With abort at cycle 100: busy=0 at cycle 101 and no done.

Source files
------------

// File: rtl/aes_round_scheduler.sv
// Byte-serial AES round sequencer: LOAD -> NR x ROUND -> FLUSH, with key requests and output flags.
// Optional feature: define AES_SCHED_ABORT_EN to add an abort input that returns the scheduler to IDLE.
module aes_round_scheduler #(
  parameter int NR  = 10,
  parameter int LAT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       encrypt,
  input  logic       in_valid,
`ifdef AES_SCHED_ABORT_EN
  input  logic       abort,
`endif
  output logic       in_ready,
  output logic       bpu_rst_synch,
  output logic       bpu_shift_left,
  output logic       sel_in,
  output logic [3:0] round_idx,
  output logic [3:0] byte_idx,
  output logic       last_round,
  output logic       key_req,
  output logic [3:0] key_idx,
  output logic       out_valid,
  output logic       done,
  output logic       load_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [4:0] LAT_L    = 5'(LAT);
  localparam logic [4:0] LAT_LAST = 5'(LAT - 1);

  state_t     r_state;
  logic [3:0] r_byte_idx;
  logic [3:0] r_round_idx;
  logic [4:0] r_flush_cnt;
  logic       r_encrypt;

  state_t     w_state_next;
  logic [3:0] w_byte_idx_next;
  logic [3:0] w_round_idx_next;
  logic [4:0] w_flush_cnt_next;
  logic       w_encrypt_next;
  logic       w_abort;
  logic       w_abort_active;

`ifdef AES_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only acts on an active block; in IDLE a simultaneous start still wins.
  assign w_abort_active = w_abort & (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_byte_idx  <= 4'd0;
      r_round_idx <= 4'd0;
      r_flush_cnt <= 5'd0;
      r_encrypt   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_byte_idx  <= w_byte_idx_next;
      r_round_idx <= w_round_idx_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_encrypt   <= w_encrypt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_byte_idx_next  = r_byte_idx;
    w_round_idx_next = r_round_idx;
    w_flush_cnt_next = r_flush_cnt;
    w_encrypt_next   = r_encrypt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next     = S_LOAD;
          w_byte_idx_next  = 4'd0;
          w_round_idx_next = 4'd0;
          w_encrypt_next   = encrypt;
        end
      end
      S_LOAD: begin
        if (!in_valid) begin
          w_state_next     = S_IDLE;
          w_byte_idx_next  = 4'd0;
          w_round_idx_next = 4'd0;
        end else begin
          w_byte_idx_next = r_byte_idx + 4'd1;
          if (r_byte_idx == 4'd15) begin
            w_state_next     = S_ROUND;
            w_round_idx_next = 4'd1;
          end
        end
      end
      S_ROUND: begin
        w_byte_idx_next = r_byte_idx + 4'd1;
        if (r_byte_idx == 4'd15) begin
          if (r_round_idx == NR_L) begin
            w_state_next     = S_FLUSH;
            w_round_idx_next = 4'd0;
            w_flush_cnt_next = 5'd0;
          end else begin
            w_round_idx_next = r_round_idx + 4'd1;
          end
        end
      end
      S_FLUSH: begin
        w_flush_cnt_next = r_flush_cnt + 5'd1;
        if (r_flush_cnt == LAT_LAST) begin
          w_state_next     = S_IDLE;
          w_flush_cnt_next = 5'd0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_abort_active) begin
      w_state_next     = S_IDLE;
      w_byte_idx_next  = 4'd0;
      w_round_idx_next = 4'd0;
      w_flush_cnt_next = 5'd0;
    end
  end

  always_comb begin
    busy           = (r_state != S_IDLE);
    in_ready       = (r_state == S_LOAD);
    bpu_rst_synch  = (r_state == S_IDLE);
    bpu_shift_left = r_encrypt & (r_state != S_IDLE);
    sel_in         = (r_state == S_ROUND);
    round_idx      = r_round_idx;
    byte_idx       = r_byte_idx;
    last_round     = (r_state == S_ROUND) && (r_round_idx == NR_L);
    load_err       = (r_state == S_LOAD) && !in_valid;
    key_req        = 1'b0;
    key_idx        = 4'd0;
    out_valid      = 1'b0;
    done           = 1'b0;
    if (!w_abort_active) begin
      key_req = (r_byte_idx == 4'd15) &&
                ((r_state == S_LOAD) || ((r_state == S_ROUND) && (r_round_idx != NR_L)));
      if (key_req) key_idx = r_round_idx + 4'd1;
      // Final bytes emerge LAT cycles after entering the last round; FLUSH is never longer than 16.
      out_valid = (r_state == S_FLUSH) ||
                  (last_round && ({1'b0, r_byte_idx} >= LAT_L));
      done      = (r_state == S_FLUSH) && (r_flush_cnt == LAT_LAST);
    end
  end

endmodule
